// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-chain and display signals between the stopwatch controller
// and its surroundings. master = controller side, slave = button front-end,
// counter chain and display mux side.
interface stopwatch_ctrl_if;
  localparam int unsigned BCD_W = 16;

  // Pre-debounced one-cycle button pulses
  logic             btn_start_stop;
  logic             btn_clear;
  logic             btn_mode;
  logic             btn_lap;

  // BCD values into the controller
  logic [BCD_W-1:0] preset_value;
  logic [BCD_W-1:0] cnt_value;

  // Counter-chain controls
  logic             ctr_count_enb;
  logic             ctr_load_cnt;
  logic [BCD_W-1:0] ctr_load_value;
  logic             ctr_cfg_mode;

  // Display and status
  logic [BCD_W-1:0] disp_value;
  logic             running;
  logic             done;

  modport master (
    input  btn_start_stop, btn_clear, btn_mode, btn_lap,
    input  preset_value, cnt_value,
    output ctr_count_enb, ctr_load_cnt, ctr_load_value, ctr_cfg_mode,
    output disp_value, running, done
  );

  modport slave (
    output btn_start_stop, btn_clear, btn_mode, btn_lap,
    output preset_value, cnt_value,
    input  ctr_count_enb, ctr_load_cnt, ctr_load_value, ctr_cfg_mode,
    input  disp_value, running, done
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/done sequencer for a 4-digit BCD counter chain.
// Prescales sys_clk into count ticks, issues count-enable/load/mode controls
// and halts the chain at its terminal value instead of letting it wrap.
// Optional feature macro: STOPWATCH_LAP_EN (lap hold of the displayed value).
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  stopwatch_ctrl_if.master   bus
);

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [BCD_W-1:0]   UP_TERM   = 16'h9999;
  localparam logic [BCD_W-1:0]   DN_TERM   = 16'h0000;
  localparam logic [BCD_W-1:0]   UP_START  = 16'h0000;

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;     // 1 = up, 0 = down
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic               tick_c;
  logic               terminal_c;
  logic [BCD_W-1:0]   preset_clamped_c;

  // Force any non-decimal preset digit to 9 so the chain always loads valid BCD
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Tick and terminal-value decode
  always_comb begin
    tick_c           = (state_q == S_RUN) && (presc_q == PRESC_MAX);
    terminal_c       = mode_q ? (bus.cnt_value == UP_TERM)
                              : (bus.cnt_value == DN_TERM);
    preset_clamped_c = clamp_bcd(bus.preset_value);
  end

  // Next-state, mode and prescaler; priority clear > start_stop > mode > tick
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    case (state_q)
      S_CLR: begin
        presc_d = '0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.btn_clear) begin
          state_d = S_CLR;
        end else if (bus.btn_start_stop) begin
          state_d = S_RUN;
        end else if (bus.btn_mode) begin
          mode_d  = ~mode_q;
          state_d = S_CLR;
        end
      end
      S_RUN: begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
        if (bus.btn_clear) begin
          state_d = S_CLR;
        end else if (bus.btn_start_stop) begin
          state_d = S_PAUSE;
        end else if (tick_c && terminal_c) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (bus.btn_clear) begin
          state_d = S_CLR;
        end else if (bus.btn_start_stop) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.btn_clear) state_d = S_CLR;
      end
      default: begin
        state_d = S_CLR;
      end
    endcase
  end

  // State, mode and prescaler registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_CLR;
      mode_q  <= 1'b1;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic             lap_hold_q, lap_hold_d;
  logic [BCD_W-1:0] lap_q, lap_d;

  // Lap hold toggles in RUN/PAUSE; a clear in the same cycle wins
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (state_q == S_CLR) begin
      lap_hold_d = 1'b0;
    end else if (((state_q == S_RUN) || (state_q == S_PAUSE)) &&
                 bus.btn_lap && !bus.btn_clear) begin
      lap_hold_d = ~lap_hold_q;
      if (!lap_hold_q) lap_d = bus.cnt_value;
    end
  end

  // Lap hold and captured value registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
    end
  end
`else
  logic lap_unused_c;
  assign lap_unused_c = bus.btn_lap;
`endif

  // Output decode; reset forces a load of zero and up mode immediately
  always_comb begin
    bus.ctr_count_enb  = 1'b0;
    bus.ctr_load_cnt   = 1'b1;
    bus.ctr_load_value = UP_START;
    bus.ctr_cfg_mode   = 1'b1;
    bus.running        = 1'b0;
    bus.done           = 1'b0;
    bus.disp_value     = bus.cnt_value;
    if (!sys_rst) begin
      bus.ctr_count_enb  = tick_c && !terminal_c &&
                           !bus.btn_clear && !bus.btn_start_stop;
      bus.ctr_load_cnt   = (state_q == S_CLR);
      bus.ctr_load_value = mode_q ? UP_START : preset_clamped_c;
      bus.ctr_cfg_mode   = mode_q;
      bus.running        = (state_q == S_RUN);
      bus.done           = (state_q == S_DONE);
`ifdef STOPWATCH_LAP_EN
      if (lap_hold_q) bus.disp_value = lap_q;
`endif
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4 and a behavioural BCD chain.
module tb_stopwatch_ctrl;
  localparam int unsigned TICK_DIV = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] chain_q;
  logic        force_req;
  logic [15:0] force_val;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (sw_if)
  );

  always #5 sys_clk = ~sys_clk;

  // One BCD step of the 4-digit chain, up or down, with digit carry/borrow
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic [3:0]  d;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = r[i*4 +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) d = 4'd0; else begin d = 4'(d + 4'd1); c = 1'b0; end
        end else begin
          if (d == 4'd0) d = 4'd9; else begin d = 4'(d - 4'd1); c = 1'b0; end
        end
      end
      r[i*4 +: 4] = d;
    end
    return r;
  endfunction

  // Behavioural counter chain driven by the controller
  always_ff @(posedge sys_clk) begin
    if (force_req)                 chain_q <= force_val;
    else if (sw_if.ctr_load_cnt)   chain_q <= sw_if.ctr_load_value;
    else if (sw_if.ctr_count_enb)  chain_q <= bcd_step(chain_q, sw_if.ctr_cfg_mode);
  end

  assign sw_if.cnt_value = chain_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of button inputs; returns at the following negedge
  task automatic cyc(input logic s, input logic c, input logic m, input logic l);
    @(posedge sys_clk);
    #1;
    sw_if.btn_start_stop = s;
    sw_if.btn_clear      = c;
    sw_if.btn_mode       = m;
    sw_if.btn_lap        = l;
    @(negedge sys_clk);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() > 0) chk(tag, obs, exp_q.pop_front());
    else chk({tag, "_extra"}, 32'(sw_if.ctr_count_enb), 32'd0);
  endtask

  initial begin
    int n;
    int en_cnt;
    logic [15:0] lap_exp;

    sys_rst = 1'b1;
    force_req = 1'b0;
    force_val = 16'h0000;
    sw_if.btn_start_stop = 1'b0;
    sw_if.btn_clear = 1'b0;
    sw_if.btn_mode = 1'b0;
    sw_if.btn_lap = 1'b0;
    sw_if.preset_value = 16'h0000;

    // Reset held three cycles
    repeat (3) cyc(0, 0, 0, 0);
    chk("rst_load_cnt", 32'(sw_if.ctr_load_cnt), 32'd1);
    chk("rst_load_val", 32'(sw_if.ctr_load_value), 32'h0000);
    chk("rst_cfg_mode", 32'(sw_if.ctr_cfg_mode), 32'd1);
    chk("rst_running", 32'(sw_if.running), 32'd0);
    chk("rst_done", 32'(sw_if.done), 32'd0);
    chk("rst_enb", 32'(sw_if.ctr_count_enb), 32'd0);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("clr_after_rst", 32'(sw_if.ctr_load_cnt), 32'd1);
    cyc(0, 0, 0, 0);
    chk("idle_load_cnt", 32'(sw_if.ctr_load_cnt), 32'd0);
    chk("idle_cnt", 32'(chain_q), 32'h0000);

    // Up run for 40 cycles: enables at offsets 3,7,...,39
    cyc(1, 0, 0, 0);
    chk("idle_running", 32'(sw_if.running), 32'd0);
    for (int j = 0; j < 10; j++) exp_q.push_back(32'(3 + 4 * j));
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0);
      if (i == 0) chk("run_running", 32'(sw_if.running), 32'd1);
      if (sw_if.ctr_count_enb) sb_pop("enb_pos", 32'(i));
    end
    cyc(0, 0, 0, 0);
    chk("run40_cnt", 32'(chain_q), 32'h0010);
    chk("run40_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("run40_disp", 32'(sw_if.disp_value), 32'h0010);

    // Pause after two cycles of the first tick period, resume after 20
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("clr_load_cnt", 32'(sw_if.ctr_load_cnt), 32'd1);
    cyc(0, 0, 0, 0);
    chk("clr_cnt", 32'(chain_q), 32'h0000);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc((i == 19) ? 1'b1 : 1'b0, 0, 0, 0);
      if (i == 0) chk("pause_running", 32'(sw_if.running), 32'd0);
      if (sw_if.ctr_count_enb) en_cnt++;
    end
    chk("pause_enb_count", 32'(en_cnt), 32'd0);
    cyc(0, 0, 0, 0);
    chk("resume_running", 32'(sw_if.running), 32'd1);
    chk("resume_enb0", 32'(sw_if.ctr_count_enb), 32'd0);
    cyc(0, 0, 0, 0);
    chk("resume_enb1", 32'(sw_if.ctr_count_enb), 32'd1);
    cyc(0, 0, 0, 0);
    chk("resume_cnt", 32'(chain_q), 32'h0001);

    // Down count from preset 0003 to DONE without wrapping
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    sw_if.preset_value = 16'h0003;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("dn_cfg_mode", 32'(sw_if.ctr_cfg_mode), 32'd0);
    chk("dn_load_cnt", 32'(sw_if.ctr_load_cnt), 32'd1);
    chk("dn_load_val", 32'(sw_if.ctr_load_value), 32'h0003);
    cyc(0, 0, 0, 0);
    chk("dn_idle_cnt", 32'(chain_q), 32'h0003);
    exp_q.push_back(32'h0003);
    exp_q.push_back(32'h0002);
    exp_q.push_back(32'h0001);
    cyc(1, 0, 0, 0);
    n = 0;
    while (!sw_if.done && n < 40) begin
      cyc(0, 0, 0, 0);
      if (sw_if.ctr_count_enb) sb_pop("dn_enb_cnt", 32'(chain_q));
      n++;
    end
    chk("dn_done", 32'(sw_if.done), 32'd1);
    chk("dn_cnt_final", 32'(chain_q), 32'h0000);
    chk("dn_sb_empty", 32'(exp_q.size()), 32'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("done_ignore_start", 32'(sw_if.done), 32'd1);
    chk("done_not_running", 32'(sw_if.running), 32'd0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("done_clr_load", 32'(sw_if.ctr_load_cnt), 32'd1);
    chk("done_clr_val", 32'(sw_if.ctr_load_value), 32'h0003);
    cyc(0, 0, 0, 0);
    chk("done_clr_cnt", 32'(chain_q), 32'h0003);

    // Preset digits above 9 load as 9
    sw_if.preset_value = 16'h00A5;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("clamp_load_val", 32'(sw_if.ctr_load_value), 32'h0095);
    cyc(0, 0, 0, 0);
    chk("clamp_cnt", 32'(chain_q), 32'h0095);

    // Up mode from 9998: one enable to 9999, then DONE
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("up_cfg_mode", 32'(sw_if.ctr_cfg_mode), 32'd1);
    chk("up_load_val", 32'(sw_if.ctr_load_value), 32'h0000);
    cyc(0, 0, 0, 0);
    force_val = 16'h9998;
    force_req = 1'b1;
    cyc(0, 0, 0, 0);
    force_req = 1'b0;
    chk("force_cnt", 32'(chain_q), 32'h9998);
    exp_q.push_back(32'h9998);
    cyc(1, 0, 0, 0);
    n = 0;
    while (!sw_if.done && n < 40) begin
      cyc(0, 0, 0, 0);
      if (sw_if.ctr_count_enb) sb_pop("up_enb_cnt", 32'(chain_q));
      n++;
    end
    chk("up_done", 32'(sw_if.done), 32'd1);
    chk("up_no_wrap", 32'(chain_q), 32'h9999);
    chk("up_sb_empty", 32'(exp_q.size()), 32'd0);

    // Lap hold at 0005 while the chain runs on to 0008
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lap_start_cnt", 32'(chain_q), 32'h0000);
    cyc(1, 0, 0, 0);
    n = 0;
    while (chain_q != 16'h0005 && n < 100) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("lap_reach5", 32'(chain_q), 32'h0005);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    n = 0;
    while (chain_q != 16'h0008 && n < 100) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("lap_reach8", 32'(chain_q), 32'h0008);
`ifdef STOPWATCH_LAP_EN
    lap_exp = 16'h0005;
`else
    lap_exp = chain_q;
`endif
    chk("lap_disp_held", 32'(sw_if.disp_value), 32'(lap_exp));
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("lap_disp_release", 32'(sw_if.disp_value), 32'(chain_q));

    // Reset in the middle of a run
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_running", 32'(sw_if.running), 32'd0);
    chk("mid_rst_load", 32'(sw_if.ctr_load_cnt), 32'd1);
    chk("mid_rst_val", 32'(sw_if.ctr_load_value), 32'h0000);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("mid_rst_clr", 32'(sw_if.ctr_load_cnt), 32'd1);
    chk("mid_rst_cnt", 32'(chain_q), 32'h0000);
    chk("mid_rst_disp", 32'(sw_if.disp_value), 32'h0000);
    cyc(0, 0, 0, 0);
    chk("mid_rst_idle", 32'(sw_if.ctr_load_cnt), 32'd0);
    chk("mid_rst_idle_run", 32'(sw_if.running), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch's 4-digit BCD decade-counter chain. It turns pre-debounced button pulses into count-enable, load and up/down-mode controls, and owns the run/pause/done state machine. It prescales `sys_clk` into count ticks and stops the chain at its terminal value rather than letting it wrap. It sits between the button front-end and the counter chain, and feeds the display mux.

## Interface
Parameters:
- `TICK_DIV`, default 100000: `sys_clk` cycles per count tick; must be ≥2. The prescaler is `$clog2(TICK_DIV)` bits wide.

Ports:
- `sys_clk`: input, 1 bit. Single clock; all logic is rising-edge.
- `sys_rst`: input, 1 bit. Synchronous, active-high reset.
- `btn_start_stop`: input, 1 bit. One-cycle pulse: start, pause or resume.
- `btn_clear`: input, 1 bit. One-cycle pulse: reload the chain.
- `btn_mode`: input, 1 bit. One-cycle pulse: toggle up/down mode; honoured in IDLE only.
- `btn_lap`: input, 1 bit. One-cycle pulse: lap hold toggle; see Configuration.
- `preset_value`: input, 16 bits. Four BCD digits used as the down-count start value.
- `cnt_value`: input, 16 bits. Current BCD value of the counter chain.
- `ctr_count_enb`: output, 1 bit. Count enable to the least-significant digit; carry is chained externally.
- `ctr_load_cnt`: output, 1 bit. Synchronous load strobe to all digits.
- `ctr_load_value`: output, 16 bits. BCD load data.
- `ctr_cfg_mode`: output, 1 bit. 1 = up, 0 = down.
- `disp_value`: output, 16 bits. Value to display.
- `running`: output, 1 bit. High in RUN.
- `done`: output, 1 bit. High in DONE.

## Operation
- States: CLR, IDLE, RUN, PAUSE, DONE. The state register, mode register and prescaler are registered; all outputs are combinational decodes of them.
- Reset effects:
  - state ← CLR, mode ← 1 (up), prescaler ← 0, lap hold ← 0.
  - While `sys_rst` is high, outputs read: `ctr_load_cnt`=1, `ctr_load_value`=0x0000, `ctr_count_enb`=0, `ctr_cfg_mode`=1, `running`=0, `done`=0, `disp_value`=`cnt_value`.
- CLR:
  - `ctr_load_cnt`=1.
  - `ctr_load_value` = 0x0000 if mode is up, else the clamped `preset_value` (each nibble >9 is forced to 9).
  - Prescaler ← 0.
  - Always moves to IDLE on the next cycle.
- Button priority each cycle: clear > start_stop > mode > terminal tick.
- IDLE transitions:
  - `btn_clear` → CLR.
  - `btn_start_stop` → RUN.
  - `btn_mode` → toggle mode, then → CLR (chain reloaded for the new mode).
- RUN transitions:
  - `btn_clear` → CLR.
  - `btn_start_stop` → PAUSE.
  - Tick while `cnt_value` is terminal → DONE. Terminal is 0x9999 in up mode, 0x0000 in down mode.
- PAUSE transitions:
  - `btn_clear` → CLR.
  - `btn_start_stop` → RUN.
  - The prescaler holds its value, so resume continues the partial tick.
- DONE: `done`=1; `btn_clear` → CLR; all other buttons are ignored.
- `btn_mode` is ignored outside IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only, wrapping to 0.
  - tick = (prescaler == TICK_DIV-1) && state == RUN.
- Count enable: `ctr_count_enb` = tick && !terminal && !`btn_clear` && !`btn_start_stop`. A tick that coincides with a button press is dropped.
- The chain therefore never wraps; the controller halts it at the terminal value.
- `ctr_cfg_mode` reflects the mode register in every state.

## Timing
- Button pulse at edge n → new state visible after edge n+1. Example: `running` rises one cycle after `btn_start_stop` is sampled.
- First tick after an IDLE→RUN entry arrives exactly TICK_DIV cycles after entry.
- `ctr_count_enb` is one cycle wide, once per TICK_DIV cycles in RUN. The counter updates on that same edge, so `cnt_value` changes in the next cycle.
- Terminal check uses `cnt_value` in the tick cycle. RUN→DONE takes effect one cycle after the tick, and no enable is issued for that tick.
- CLR lasts exactly one cycle; the chain holds the load value from the following cycle.
- Reset mid-run:
  - The next cycle after reset is asserted shows the reset values.
  - The chain is loaded with 0x0000 throughout reset.
  - One further CLR cycle follows reset release.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - `btn_lap` in RUN or PAUSE toggles a lap hold.
  - On set, `cnt_value` is captured into a lap register and `disp_value` shows the lap register.
  - On release, `disp_value` shows `cnt_value` again.
  - Counting continues underneath while held.
  - CLR and reset release the hold.
  - `btn_lap` is ignored in IDLE and DONE.
- Undefined:
  - `btn_lap` is ignored, and no lap register is synthesised.
  - `disp_value` = `cnt_value` always.

## Test plan
All scenarios use `TICK_DIV`=4 and a behavioural 4-digit BCD chain model.
- Reset held 3 cycles → `ctr_load_cnt`=1, `ctr_load_value`=0x0000, `ctr_cfg_mode`=1, `running`=0; IDLE after one CLR cycle; `cnt_value`=0x0000.
- Start in up mode, run 40 cycles → 10 single-cycle enables spaced 4 cycles apart; `cnt_value`=0x0010.
- After 2 cycles of the first tick period, pause for 20 cycles, then resume → the next enable arrives 2 cycles after resume; no enables during PAUSE.
- `btn_mode` in IDLE with `preset_value`=0x0003, then start → counts down 0003, 0002, 0001, 0000; the next tick issues no enable and `done`=1. `btn_start_stop` in DONE has no effect; `btn_clear` reloads 0x0003.
- Up mode with chain forced to 0x9998 → one enable to 0x9999, then DONE with no wrap. `preset_value`=0x00A5 in down mode → loads 0x0095.
- With `STOPWATCH_LAP_EN` defined: lap at 0x0005 → `disp_value` holds 0x0005 while `cnt_value` reaches 0x0008; second lap → `disp_value` = `cnt_value`. Without the macro, `disp_value` always equals `cnt_value`.
